// File: rtl/ysyx_lsu_sq_if.sv
// Bundle of the store queue's commit, memory-write and load-forwarding signals.
// The slave modport is the queue's view and the master modport is the surrounding pipeline's view.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_lsu_sq_if #(
    parameter int XLEN = `YSYX_XLEN
);
    logic            cm_valid;
    logic            cm_store;
    logic [1:0]      cm_size;
    logic [XLEN-1:0] cm_waddr;
    logic [XLEN-1:0] cm_wdata;
    logic            sq_ready;
    logic            sq_empty;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;

    logic [XLEN-1:0] ld_addr;
    logic            ld_hit;
    logic [XLEN-1:0] ld_data;
    logic            ld_conflict;

    modport master (
        output cm_valid, cm_store, cm_size, cm_waddr, cm_wdata,
        output mem_req_ready, mem_ack, ld_addr,
        input  sq_ready, sq_empty, mem_req_valid, mem_addr, mem_wdata, mem_wstrb,
        input  ld_hit, ld_data, ld_conflict
    );

    modport slave (
        input  cm_valid, cm_store, cm_size, cm_waddr, cm_wdata,
        input  mem_req_ready, mem_ack, ld_addr,
        output sq_ready, sq_empty, mem_req_valid, mem_addr, mem_wdata, mem_wstrb,
        output ld_hit, ld_data, ld_conflict
    );
endinterface

// File: rtl/ysyx_lsu_sq.sv
// Committed-store queue: in-order drain to the data-memory write port plus word-granular load forwarding.
// Optional YSYX_SQ_COALESCE_EN merges a store into the youngest entry when both target the same word.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_lsu_sq #(
    parameter int SQ_SIZE = 4,
    parameter int XLEN    = `YSYX_XLEN
) (
    input  logic          clock,
    input  logic          reset,
    ysyx_lsu_sq_if.slave  bus
);
    localparam int PW = $clog2(SQ_SIZE);
    localparam int CW = PW + 1;
    localparam int AW = XLEN - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t           state;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SQ_SIZE-1:0] ent_valid;
    logic [AW-1:0]    ent_addr [SQ_SIZE];
    logic [XLEN-1:0]  ent_data [SQ_SIZE];
    logic [3:0]       ent_strb [SQ_SIZE];

    logic             full;
    logic             merge;
    logic             enq;
    logic             alloc;
    logic             pop;
    logic             ready;
    logic [AW-1:0]    cm_word;
    logic [1:0]       cm_off;
    logic [3:0]       size_mask;
    logic [3:0]       new_strb;
    logic [XLEN-1:0]  new_data;

    assign full    = (count == CW'(SQ_SIZE));
    assign cm_word = bus.cm_waddr[XLEN-1:2];
    assign cm_off  = bus.cm_waddr[1:0];

    always_comb begin
        size_mask = 4'hF;
        case (bus.cm_size)
            2'd0:    size_mask = 4'h1;
            2'd1:    size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    end

    assign new_strb = size_mask << cm_off;
    assign new_data = bus.cm_wdata << {cm_off, 3'b000};

`ifdef YSYX_SQ_COALESCE_EN
    logic [PW-1:0] youngest;
    logic          merge_ok;

    // The head is frozen once it has been offered to memory, so it can only absorb stores while idle.
    assign youngest = tail - PW'(1);
    assign merge_ok = (count != '0) && (ent_addr[youngest] == cm_word) &&
                      !((youngest == head) && (state != S_IDLE));
    assign ready    = !full || merge_ok;
    assign merge    = bus.cm_valid && bus.cm_store && merge_ok;
`else
    assign ready    = !full;
    assign merge    = 1'b0;
`endif

    assign enq   = bus.cm_valid && bus.cm_store && ready;
    assign alloc = enq && !merge;
    assign pop   = (state == S_WAIT) && bus.mem_ack;

    // Control state: drain FSM, pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            case (state)
                S_IDLE: if (count != '0) state <= S_REQ;
                S_REQ:  if (bus.mem_req_ready) state <= S_WAIT;
                S_WAIT: if (bus.mem_ack) state <= (count > CW'(1)) ? S_REQ : S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end

            case ({alloc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; it is only observed through valid entries.
    always_ff @(posedge clock) begin
        if (alloc) begin
            ent_addr[tail] <= cm_word;
            ent_data[tail] <= new_data;
            ent_strb[tail] <= new_strb;
        end
`ifdef YSYX_SQ_COALESCE_EN
        else if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (new_strb[b]) ent_data[youngest][8*b +: 8] <= new_data[8*b +: 8];
            end
            ent_strb[youngest] <= ent_strb[youngest] | new_strb;
        end
`endif
    end

    logic          fwd_found;
    logic [PW-1:0] fwd_idx;
    logic [PW-1:0] scan_idx;

    // Walk from oldest to youngest so the last match seen is the one nearest the tail.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            scan_idx = head + PW'(i);
            if (ent_valid[scan_idx] && (ent_addr[scan_idx] == bus.ld_addr[XLEN-1:2])) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
    end

    assign bus.ld_hit      = fwd_found && (ent_strb[fwd_idx] == 4'hF);
    assign bus.ld_conflict = fwd_found && (ent_strb[fwd_idx] != 4'hF);
    assign bus.ld_data     = bus.ld_hit ? ent_data[fwd_idx] : '0;

    assign bus.sq_ready      = ready;
    assign bus.sq_empty      = (count == '0) && (state == S_IDLE);
    assign bus.mem_req_valid = (state == S_REQ);
    assign bus.mem_addr      = (state == S_REQ) ? {ent_addr[head], 2'b00} : '0;
    assign bus.mem_wdata     = (state == S_REQ) ? ent_data[head] : '0;
    assign bus.mem_wstrb     = (state == S_REQ) ? ent_strb[head] : 4'h0;
endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// Testbench for ysyx_lsu_sq: directed scenarios plus a randomized run against a queue-based reference model.
// Honours YSYX_SQ_COALESCE_EN the same way the design does.
module tb_ysyx_lsu_sq;
    localparam int SQ_SIZE = 4;
    localparam int XLEN    = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    ysyx_lsu_sq_if #(.XLEN(XLEN)) bus ();

    ysyx_lsu_sq #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum {PH_IDLE, PH_REQ, PH_WAIT} phase_t;

    // Reference model: the queue contents in age order plus where the drain handshake stands.
    logic [29:0] m_addr [$];
    logic [31:0] m_data [$];
    logic [3:0]  m_strb [$];
    phase_t      m_phase;

    logic        e_ready, e_empty, e_req, e_hit, e_conf;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_wstrb;

    function automatic bit model_merge_ok();
`ifdef YSYX_SQ_COALESCE_EN
        if (m_addr.size() == 0) return 1'b0;
        if (m_addr[$] != bus.cm_waddr[31:2]) return 1'b0;
        if (m_addr.size() == 1 && m_phase != PH_IDLE) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_eval();
        e_ready = (m_addr.size() < SQ_SIZE) || model_merge_ok();
        e_empty = (m_addr.size() == 0) && (m_phase == PH_IDLE);
        e_req   = (m_phase == PH_REQ);
        e_addr  = e_req ? {m_addr[0], 2'b00} : 32'h0;
        e_wdata = e_req ? m_data[0] : 32'h0;
        e_wstrb = e_req ? m_strb[0] : 4'h0;
        e_hit   = 1'b0;
        e_conf  = 1'b0;
        e_data  = 32'h0;
        for (int i = m_addr.size() - 1; i >= 0; i--) begin
            if (m_addr[i] == bus.ld_addr[31:2]) begin
                if (m_strb[i] == 4'hF) begin
                    e_hit  = 1'b1;
                    e_data = m_data[i];
                end else begin
                    e_conf = 1'b1;
                end
                break;
            end
        end
    endtask

    task automatic model_clear();
        m_addr.delete();
        m_data.delete();
        m_strb.delete();
        m_phase = PH_IDLE;
    endtask

    // Advance the model with the inputs currently driven, then cross one clock edge.
    task automatic tick();
        bit          enq, pop, mrg;
        logic [3:0]  mask, s;
        logic [31:0] d, t;
        int          off;
        if (bus.cm_valid && bus.cm_store) begin
            checks++;
            if (bus.sq_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL commit_gated: sq_ready=%0b required 1", bus.sq_ready);
            end
        end
        mrg  = model_merge_ok();
        enq  = bus.cm_valid && bus.cm_store && ((m_addr.size() < SQ_SIZE) || mrg);
        pop  = (m_phase == PH_WAIT) && bus.mem_ack;
        case (m_phase)
            PH_IDLE: if (m_addr.size() > 0) m_phase = PH_REQ;
            PH_REQ:  if (bus.mem_req_ready) m_phase = PH_WAIT;
            default: if (bus.mem_ack) m_phase = (m_addr.size() > 1) ? PH_REQ : PH_IDLE;
        endcase
        off  = int'(bus.cm_waddr[1:0]);
        mask = (bus.cm_size == 2'd0) ? 4'h1 : (bus.cm_size == 2'd1) ? 4'h3 : 4'hF;
        s    = mask << off;
        d    = bus.cm_wdata << (8 * off);
        if (pop) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
            void'(m_strb.pop_front());
        end
        if (enq) begin
            if (mrg) begin
                t = m_data[m_data.size() - 1];
                for (int b = 0; b < 4; b++) if (s[b]) t[8*b +: 8] = d[8*b +: 8];
                m_data[m_data.size() - 1] = t;
                m_strb[m_strb.size() - 1] = m_strb[m_strb.size() - 1] | s;
            end else begin
                m_addr.push_back(bus.cm_waddr[31:2]);
                m_data.push_back(d);
                m_strb.push_back(s);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_commit(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        bus.cm_valid = 1'b1;
        bus.cm_store = 1'b1;
        bus.cm_size  = size;
        bus.cm_waddr = addr;
        bus.cm_wdata = data;
        tick();
        bus.cm_valid = 1'b0;
        bus.cm_store = 1'b0;
    endtask

    task automatic do_reset();
        bus.cm_valid      = 1'b0;
        bus.cm_store      = 1'b0;
        bus.cm_size       = 2'd0;
        bus.cm_waddr      = 32'h0;
        bus.cm_wdata      = 32'h0;
        bus.mem_req_ready = 1'b0;
        bus.mem_ack       = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.ld_addr = $urandom;
        do_reset();
        checks++;
        if ({bus.sq_ready, bus.sq_empty, bus.mem_req_valid, bus.ld_hit, bus.ld_conflict} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 11000",
                     {bus.sq_ready, bus.sq_empty, bus.mem_req_valid, bus.ld_hit, bus.ld_conflict});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.ld_data} !== 100'h0) begin
            errors++;
            $display("[TB] FAIL reset_buses: addr=%h wdata=%h wstrb=%h ld_data=%h want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.ld_data);
        end
    endtask

    task automatic test_single_word();
        do_commit(2'd2, 32'h8000_0004, 32'h1122_3344);
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_latency_n1: mem_req_valid=%0b want 0", bus.mem_req_valid);
        end
        tick();
        checks++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
            {1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF}) begin
            errors++;
            $display("[TB] FAIL sw_request: valid=%0b addr=%h wdata=%h wstrb=%h want 1 80000004 11223344 f",
                     bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        checks++;
        if (bus.sq_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_empty_after_ack: sq_empty=%0b want 1", bus.sq_empty);
        end
    endtask

    task automatic test_byte_store();
        do_commit(2'd0, 32'h8000_0003, 32'h1234_56AB);
        tick();
        checks++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
            {1'b1, 32'h8000_0000, 32'hAB00_0000, 4'b1000}) begin
            errors++;
            $display("[TB] FAIL sb_request: valid=%0b addr=%h wdata=%h wstrb=%b want 1 80000000 ab000000 1000",
                     bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    endtask

    task automatic test_full_forward();
        logic [31:0] d [5];
        int n;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            do_commit(2'd2, 32'h0000_1000 + 32'(4 * i), d[i]);
        end
        checks++;
        if (bus.sq_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ready: sq_ready=%0b want 0", bus.sq_ready);
        end
        bus.ld_addr = 32'h0000_1008;
        #1;
        checks++;
        if ({bus.ld_hit, bus.ld_conflict, bus.ld_data} !== {1'b1, 1'b0, d[2]}) begin
            errors++;
            $display("[TB] FAIL full_forward: hit=%0b conflict=%0b data=%h want 1 0 %h",
                     bus.ld_hit, bus.ld_conflict, bus.ld_data, d[2]);
        end
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!bus.mem_req_valid && n < 20) begin tick(); n++; end
            checks++;
            if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h0000_1000 + 32'(4 * k), d[k]}) begin
                errors++;
                $display("[TB] FAIL full_drain_order: k=%0d valid=%0b addr=%h wdata=%h want 1 %h %h",
                         k, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, 32'h0000_1000 + 32'(4 * k), d[k]);
            end
            bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
            bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
            if (k == 0) begin
                checks++;
                if (bus.sq_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL full_ready_after_pop: sq_ready=%0b want 1", bus.sq_ready);
                end
                d[4] = $urandom;
                do_commit(2'd2, 32'h0000_1010, d[4]);
            end
        end
        checks++;
        if (bus.sq_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_drained_empty: sq_empty=%0b want 1", bus.sq_empty);
        end
    endtask

    task automatic test_partial_conflict();
        int reqs;
        int expect_reqs;
        bus.ld_addr = 32'h0000_0100;
        do_commit(2'd2, 32'h0000_0100, 32'hFFFF_FFFF);
        do_commit(2'd1, 32'h0000_0102, 32'h0000_1234);
        checks++;
`ifdef YSYX_SQ_COALESCE_EN
        expect_reqs = 1;
        if ({bus.ld_hit, bus.ld_conflict, bus.ld_data} !== {1'b1, 1'b0, 32'h1234_FFFF}) begin
            errors++;
            $display("[TB] FAIL partial_forward: hit=%0b conflict=%0b data=%h want 1 0 1234ffff",
                     bus.ld_hit, bus.ld_conflict, bus.ld_data);
        end
`else
        expect_reqs = 2;
        if ({bus.ld_hit, bus.ld_conflict, bus.ld_data} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL partial_forward: hit=%0b conflict=%0b data=%h want 0 1 0",
                     bus.ld_hit, bus.ld_conflict, bus.ld_data);
        end
`endif
        reqs = 0;
        for (int c = 0; c < 40 && !bus.sq_empty; c++) begin
            if (bus.mem_req_valid) begin
                reqs++;
                bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
                bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (reqs != expect_reqs || bus.sq_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL partial_drain_count: requests=%0d empty=%0b want %0d 1",
                     reqs, bus.sq_empty, expect_reqs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [5];
        int n;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            do_commit(2'd2, 32'h0000_2000 + 32'(4 * i), d[i]);
        end
        bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
        d[3] = $urandom;
        bus.mem_ack = 1'b1;
        do_commit(2'd2, 32'h0000_200C, d[3]);
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.sq_ready, bus.mem_req_valid, bus.mem_addr} !== {1'b1, 1'b1, 32'h0000_2004}) begin
            errors++;
            $display("[TB] FAIL b2b_enq_pop: ready=%0b valid=%0b addr=%h want 1 1 00002004",
                     bus.sq_ready, bus.mem_req_valid, bus.mem_addr);
        end
        d[4] = $urandom;
        do_commit(2'd2, 32'h0000_2010, d[4]);
        checks++;
        if (bus.sq_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full: sq_ready=%0b want 0", bus.sq_ready);
        end
        for (int k = 1; k < 5; k++) begin
            n = 0;
            while (!bus.mem_req_valid && n < 20) begin tick(); n++; end
            checks++;
            if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h0000_2000 + 32'(4 * k), d[k]}) begin
                errors++;
                $display("[TB] FAIL b2b_drain_order: k=%0d valid=%0b addr=%h wdata=%h want 1 %h %h",
                         k, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, 32'h0000_2000 + 32'(4 * k), d[k]);
            end
            bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
            bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.cm_store      = ($urandom_range(0, 3) != 0);
            bus.cm_size       = 2'($urandom_range(0, 3));
            bus.cm_waddr      = 32'h0000_3000 + 32'($urandom_range(0, 15));
            bus.cm_wdata      = $urandom;
            bus.ld_addr       = 32'h0000_3000 + 32'($urandom_range(0, 15));
            bus.mem_req_ready = 1'($urandom_range(0, 1));
            bus.mem_ack       = 1'($urandom_range(0, 1));
            bus.cm_valid      = 1'b0;
            #1;
            model_eval();
            bus.cm_valid = ($urandom_range(0, 1) == 1) && (e_ready || !bus.cm_store);
            #1;
            model_eval();
            checks++;
            if ({bus.sq_ready, bus.sq_empty, bus.mem_req_valid} !== {e_ready, e_empty, e_req}) begin
                errors++;
                $display("[TB] FAIL rand_flags: cycle=%0d got ready/empty/req=%b want %b",
                         c, {bus.sq_ready, bus.sq_empty, bus.mem_req_valid}, {e_ready, e_empty, e_req});
            end
            checks++;
            if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {e_addr, e_wdata, e_wstrb}) begin
                errors++;
                $display("[TB] FAIL rand_mem: cycle=%0d got %h %h %h want %h %h %h",
                         c, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, e_addr, e_wdata, e_wstrb);
            end
            checks++;
            if ({bus.ld_hit, bus.ld_conflict, bus.ld_data} !== {e_hit, e_conf, e_data}) begin
                errors++;
                $display("[TB] FAIL rand_forward: cycle=%0d got hit=%0b conflict=%0b data=%h want %0b %0b %h",
                         c, bus.ld_hit, bus.ld_conflict, bus.ld_data, e_hit, e_conf, e_data);
            end
            tick();
        end
        bus.cm_valid      = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_ack       = 1'b0;
    endtask

    task automatic test_reset_wait();
        do_reset();
        do_commit(2'd2, 32'h0000_4000, $urandom);
        tick();
        bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
        checks++;
        if (bus.sq_empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait_pre: sq_empty=%0b want 0", bus.sq_empty);
        end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({bus.mem_req_valid, bus.sq_empty, bus.sq_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL rst_wait_immediate: valid/empty/ready=%b want 011",
                     {bus.mem_req_valid, bus.sq_empty, bus.sq_ready});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.mem_req_valid, bus.sq_empty, bus.sq_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL rst_late_ack: valid/empty/ready=%b want 011",
                     {bus.mem_req_valid, bus.sq_empty, bus.sq_ready});
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single_word();
        test_byte_store();
        test_full_forward();
        test_partial_conflict();
        test_back_to_back();
        test_random();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
